// File: rtl/bcd_conv_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_conv_arbiter
//
// One sequential double-dabble binary-to-BCD engine shared between several
// requesters (e.g. hours/minutes/seconds/alarm counters). A round-robin
// arbiter grants one requester at a time, the engine converts one bit per
// cycle, and the result is latched into that requester's BCD slot, which the
// display logic reads continuously.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   req       in   [requesters]            level request, held until done[k]
//   bin_flat  in   [requesters*width]      slot k = bin_flat[k*width +: width]
//   bcd_flat  out  [requesters*bcd_width]  registered BCD results per slot
//   done      out  [requesters]            one-cycle pulse when slot k updates
//   busy      out  1                       conversion in progress
//   grant_id  out  [idw]                   current / most recent grant
// ---------------------------------------------------------------------------
module bcd_conv_arbiter #(
  parameter  int width      = 6,
  parameter  int digits     = 2,
  parameter  int requesters = 4,
  localparam int bcd_width  = digits * 4,
  localparam int idw        = (requesters > 1) ? $clog2(requesters) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [requesters-1:0]           req,
  input  logic [requesters*width-1:0]     bin_flat,
  output logic [requesters*bcd_width-1:0] bcd_flat,
  output logic [requesters-1:0]           done,
  output logic                            busy,
  output logic [idw-1:0]                  grant_id
);

  localparam int cw = $clog2(width + 1);

  // Largest binary input must fit in the BCD digits; the hardware simply
  // drops the upper digits if it does not.
  localparam longint max_bin = (longint'(1) << width) - 1;
  localparam longint max_bcd = (longint'(10) ** digits) - 1;

  generate
    if (max_bin > max_bcd) begin : g_range_check
      $error("bcd_conv_arbiter: 2**width-1 exceeds 10**digits-1, upper digits truncated");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [idw-1:0]       r_last;
  logic [idw-1:0]       w_gnt_idx;
  logic [idw-1:0]       w_cand;
  logic                 w_gnt_valid;
  logic [width-1:0]     w_bin_sel;
  logic [width-1:0]     r_sh;
  logic [bcd_width-1:0] r_acc;
  logic [bcd_width-1:0] w_corr;
  logic [cw-1:0]        r_cnt;
  logic                 w_last_step;

  // Round-robin pick: scan starting one past the last served index, wrapping.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int i = 0; i < requesters; i++) begin
      w_cand = idw'((int'(r_last) + 1 + i) % requesters);
      if (!w_gnt_valid && req[w_cand]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  // Binary operand of the winning requester.
  always_comb begin
    w_bin_sel = '0;
    for (int k = 0; k < requesters; k++) begin
      if (idw'(k) == w_gnt_idx) begin
        w_bin_sel = bin_flat[k*width +: width];
      end
    end
  end

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  always_comb begin
    w_corr = r_acc;
    for (int d = 0; d < digits; d++) begin
      if (r_acc[d*4 +: 4] >= 4'd5) begin
        w_corr[d*4 +: 4] = r_acc[d*4 +: 4] + 4'd3;
      end
    end
  end

  assign w_last_step = (r_cnt == cw'(width - 1));

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_valid) w_next = S_SHIFT;
      S_SHIFT: if (w_last_step) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: the shift/accumulate datapath is deliberately not reset: it is
  // fully loaded on every grant edge before anything consumes it.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (w_gnt_valid) begin
          r_sh  <= w_bin_sel;
          r_acc <= '0;
          r_cnt <= '0;
        end
      end
      S_SHIFT: begin
        r_acc <= {w_corr[bcd_width-2:0], r_sh[width-1]};
        r_sh  <= r_sh << 1;
        r_cnt <= r_cnt + cw'(1);
      end
      default: ;
    endcase
  end

  // Grant bookkeeping and result slots. Reset abandons any in-flight
  // conversion: no slot write, no done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= idw'(requesters - 1);
      bcd_flat <= '0;
      done     <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
    end else begin
      done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            grant_id <= w_gnt_idx;
            busy     <= 1'b1;
          end
        end
        S_DONE: begin
          for (int k = 0; k < requesters; k++) begin
            if (idw'(k) == grant_id) begin
              bcd_flat[k*bcd_width +: bcd_width] <= r_acc;
              done[k]                            <= 1'b1;
            end
          end
          r_last <= grant_id;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_arbiter
//
// Self-checking bench for bcd_conv_arbiter at default parameters (width=6,
// digits=2, requesters=4). Expected results are pushed to a scoreboard queue
// when a request is driven and popped when the matching done pulse appears.
// ---------------------------------------------------------------------------
module tb_bcd_conv_arbiter;

  localparam int W  = 6;
  localparam int D  = 2;
  localparam int R  = 4;
  localparam int BW = D * 4;
  localparam int IW = 2;

  typedef struct {
    int             idx;
    logic [BW-1:0]  bcd;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [R-1:0]      req;
  logic [R*W-1:0]    bin_flat;
  logic [R*BW-1:0]   bcd_flat;
  logic [R-1:0]      done;
  logic              busy;
  logic [IW-1:0]     grant_id;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bcd_conv_arbiter #(
    .width      (W),
    .digits     (D),
    .requesters (R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .bin_flat (bin_flat),
    .bcd_flat (bcd_flat),
    .done     (done),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference conversion by decimal arithmetic.
  function automatic logic [BW-1:0] to_bcd(input int v);
    return BW'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [BW-1:0] slot(input int k);
    return bcd_flat[k*BW +: BW];
  endfunction

  task automatic set_bin(input int k, input int v);
    bin_flat[k*W +: W] = W'(v);
  endtask

  // Waits (bounded) for any done pulse; sampled on falling edges.
  task automatic wait_done(input int budget, output int idx, output int cycles,
                           output bit ok);
    ok = 1'b0;
    idx = -1;
    cycles = 0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (|done) begin
        ok = 1'b1;
        for (int k = 0; k < R; k++) if (done[k]) idx = k;
      end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.idx = -1;
      e.bcd = 'x;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    bin_flat = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bcd_flat !== '0) begin
      n_fail++;
      $display("FAIL reset_bcd: got %h want 0", bcd_flat);
    end
    n_tests++;
    if (done !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done_busy: got done=%b busy=%b want 0/0", done, busy);
    end
    n_tests++;
    if (grant_id !== '0) begin
      n_fail++;
      $display("FAIL reset_grant: got %0d want 0", grant_id);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int idx, cyc;
    bit ok;
    exp_t e;
    set_bin(0, 47);
    req = 4'b0001;
    sb.push_back('{0, to_bcd(47)});
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_grant: got busy=%b gid=%0d want 1/0", busy, grant_id);
    end
    wait_done(20, idx, cyc, ok);
    req = '0;
    pop_exp(e);
    n_tests++;
    if (!ok || cyc != 7) begin
      n_fail++;
      $display("FAIL single_latency: got ok=%0d cycles=%0d want 1/7", ok, cyc);
    end
    n_tests++;
    if (idx != e.idx || slot(0) !== e.bcd) begin
      n_fail++;
      $display("FAIL single_result: got idx=%0d slot0=%h want %0d/%h", idx, slot(0), e.idx, e.bcd);
    end
    n_tests++;
    if (bcd_flat[R*BW-1:BW] !== '0) begin
      n_fail++;
      $display("FAIL single_others: got %h want 0", bcd_flat[R*BW-1:BW]);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_at_done: got %b want 0", busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== '0) begin
      n_fail++;
      $display("FAIL single_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_sweep();
    int idx, cyc;
    bit ok;
    exp_t e;
    for (int v = 0; v < 64; v++) begin
      set_bin(2, v);
      req = 4'b0100;
      sb.push_back('{2, to_bcd(v)});
      wait_done(20, idx, cyc, ok);
      req = '0;
      pop_exp(e);
      n_tests++;
      if (!ok || idx != e.idx || slot(2) !== e.bcd) begin
        n_fail++;
        $display("FAIL sweep_%0d: got ok=%0d idx=%0d slot2=%h want 1/%0d/%h",
                 v, ok, idx, slot(2), e.idx, e.bcd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int idx, cyc;
    bit ok;
    exp_t e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < R; k++) set_bin(k, (k + 1) * 10);
    req = 4'b1111;
    sb.push_back('{0, to_bcd(10)});
    sb.push_back('{1, to_bcd(20)});
    sb.push_back('{2, to_bcd(30)});
    sb.push_back('{3, to_bcd(40)});
    sb.push_back('{0, to_bcd(10)});
    for (int n = 0; n < 5; n++) begin
      wait_done(12, idx, cyc, ok);
      if (n == 4) req = '0;
      pop_exp(e);
      n_tests++;
      if (!ok || cyc != 8 || !$onehot(done)) begin
        n_fail++;
        $display("FAIL rr_timing_%0d: got ok=%0d cycles=%0d done=%b want 1/8/onehot",
                 n, ok, cyc, done);
      end
      n_tests++;
      if (idx != e.idx || slot(e.idx < 0 ? 0 : e.idx) !== e.bcd) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got idx=%0d bcd=%h want %0d/%h",
                 n, idx, bcd_flat, e.idx, e.bcd);
      end
    end
    n_tests++;
    if (bcd_flat !== 32'h4030_2010) begin
      n_fail++;
      $display("FAIL rr_slots: got %h want 40302010", bcd_flat);
    end
  endtask

  task automatic test_reset_midflight();
    int idx, cyc;
    bit ok, saw_done;
    exp_t e;
    saw_done = 1'b0;
    set_bin(1, 37);
    req = 4'b0010;
    @(negedge clk);
    n_tests++;
    if (grant_id !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_grant: got gid=%0d busy=%b want 1/1", grant_id, busy);
    end
    repeat (2) begin
      @(negedge clk);
      saw_done |= (|done);
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    saw_done |= (|done);
    n_tests++;
    if (busy !== 1'b0 || bcd_flat !== '0 || saw_done) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b bcd=%h saw_done=%0d want 0/0/0",
               busy, bcd_flat, saw_done);
    end
    rst = 1'b0;
    for (int k = 0; k < R; k++) set_bin(k, 50 + k);
    req = 4'b1111;
    sb.push_back('{0, to_bcd(50)});
    wait_done(12, idx, cyc, ok);
    req = '0;
    pop_exp(e);
    n_tests++;
    if (!ok || idx != e.idx || slot(0) !== e.bcd || cyc != 8) begin
      n_fail++;
      $display("FAIL mid_after_release: got ok=%0d idx=%0d slot0=%h cycles=%0d want 1/%0d/%h/8",
               ok, idx, slot(0), cyc, e.idx, e.bcd);
    end
  endtask

  task automatic test_drop_req();
    int idx, cyc, extra;
    bit ok;
    exp_t e;
    set_bin(1, 59);
    req = 4'b0010;
    sb.push_back('{1, to_bcd(59)});
    @(negedge clk);
    req[1] = 1'b0;
    set_bin(1, 12);
    wait_done(12, idx, cyc, ok);
    pop_exp(e);
    n_tests++;
    if (!ok || idx != e.idx || slot(1) !== e.bcd) begin
      n_fail++;
      $display("FAIL drop_result: got ok=%0d idx=%0d slot1=%h want 1/%0d/%h",
               ok, idx, slot(1), e.idx, e.bcd);
    end
    extra = 0;
    repeat (16) begin
      @(negedge clk);
      if (|done || busy) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL drop_no_regrant: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_fairness();
    int idx, cyc;
    bit ok;
    exp_t e;
    set_bin(3, 33);
    set_bin(1, 11);
    req = 4'b1000;
    sb.push_back('{3, to_bcd(33)});
    sb.push_back('{1, to_bcd(11)});
    sb.push_back('{3, to_bcd(33)});
    repeat (3) @(negedge clk);
    req[1] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_done(20, idx, cyc, ok);
      if (n == 1) req[1] = 1'b0;
      if (n == 2) req = '0;
      pop_exp(e);
      n_tests++;
      if (!ok || idx != e.idx || slot(e.idx < 0 ? 0 : e.idx) !== e.bcd) begin
        n_fail++;
        $display("FAIL fair_%0d: got ok=%0d idx=%0d bcd=%h want 1/%0d/%h",
                 n, ok, idx, bcd_flat, e.idx, e.bcd);
      end
    end
    n_tests++;
    if (slot(0) !== to_bcd(50)) begin
      n_fail++;
      $display("FAIL fair_slot0_untouched: got %h want %h", slot(0), to_bcd(50));
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    bin_flat = '0;
    test_reset();
    test_single();
    test_sweep();
    test_back_to_back();
    test_reset_midflight();
    test_drop_req();
    test_fairness();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
